// File: rtl/biu_pf.sv
// Bus interface unit: instruction prefetch FIFO plus one data load/store, sharing a single bus.
// Bus strobes are decoded from state; fetch results land in the FIFO, data results are registered.
module biu_pf #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int PF_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pf_flush,
    input  logic [AW-1:0]     pf_pc,
    output logic [31:0]       ins,
    output logic              ins_vld,
    output logic [AW-1:0]     ins_pc,
    output logic              ins_fault,
    input  logic              ins_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_done,
    output logic              mem_mis,
    output logic              mem_fault,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    output logic [DW/8-1:0]   bus_be,
    output logic              bus_rd_n,
    output logic              bus_wr_n,
    input  logic [DW-1:0]     bus_rdata,
    input  logic              bus_rdy,
    input  logic              bus_acc_fault
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);
    localparam int PW = $clog2(PF_DEPTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, IFETCH, DACC, DRESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   fa_q, fa_d;
    logic            hold_q, hold_d;
    logic            discard_q, discard_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_prev_q, done_prev_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            flt_q, flt_d;
    logic [PW-1:0]   rd_idx_q, rd_idx_d;
    logic [PW-1:0]   wr_idx_q, wr_idx_d;
    logic [PW:0]     count_q, count_d;

    logic [31:0]     fifo_ins_q [PF_DEPTH];
    logic [AW-1:0]   fifo_pc_q  [PF_DEPTH];
    logic            fifo_flt_q [PF_DEPTH];

    logic            full, empty, pop, push, push_flt;
    logic [31:0]     push_ins;
    logic [AW-1:0]   push_pc;
    logic [OW-1:0]   offset;
    logic            mis;
    logic [BW-1:0]   be_base;
    logic [DW-1:0]   rmask;
    logic [31:0]     fetch_word;
    logic            tmo, acc_end, acc_flt;

    assign full   = (count_q == (PW+1)'(PF_DEPTH));
    assign empty  = (count_q == '0);
    assign pop    = ins_ack && !empty && !pf_flush;
    assign offset = mem_addr[OW-1:0];

    assign fetch_word = 32'(bus_rdata >> ((DW == 64) ? {fa_q[2], 5'b0} : 6'd0));

    // Timeout only fires on a cycle the bus has not already answered.
    assign tmo     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT)) && !bus_rdy;
    assign acc_end = bus_rdy || bus_acc_fault || tmo;
    assign acc_flt = bus_acc_fault || tmo;

    always_comb begin
        mis     = 1'b0;
        be_base = BW'(8'hFF);
        rmask   = '1;
        case (mem_size)
            2'd0: begin be_base = BW'(8'h01); rmask = DW'(64'hFF); end
            2'd1: begin mis = mem_addr[0];      be_base = BW'(8'h03); rmask = DW'(64'hFFFF); end
            2'd2: begin mis = |mem_addr[1:0];   be_base = BW'(8'h0F); rmask = DW'(64'hFFFF_FFFF); end
            default: mis = |mem_addr[2:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fa_d        = fa_q;
        hold_d      = hold_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mis_d       = mis_q;
        flt_d       = flt_q;
        done_prev_d = (state_q == DRESP);
        push        = 1'b0;
        push_flt    = 1'b0;
        push_ins    = '0;
        push_pc     = fa_q;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_be      = '0;
        bus_rd_n    = 1'b1;
        bus_wr_n    = 1'b1;
        mem_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req && !done_prev_q) begin
                    state_d = DACC;
                    cnt_d   = '0;
                end else if (!full && !hold_q && !pf_flush) begin
                    if (|ptr_q[1:0]) begin
                        push     = 1'b1;
                        push_flt = 1'b1;
                        push_pc  = ptr_q;
                        hold_d   = 1'b1;
                    end else begin
                        state_d = IFETCH;
                        fa_d    = ptr_q;
                        cnt_d   = '0;
                    end
                end
            end
            IFETCH: begin
                bus_addr = {fa_q[AW-1:2], 2'b00};
                bus_rd_n = 1'b0;
                bus_be   = '1;
                if (acc_end) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !pf_flush) begin
                        push = 1'b1;
                        if (acc_flt) begin
                            push_flt = 1'b1;
                            hold_d   = 1'b1;
                        end else begin
                            push_ins = fetch_word;
                            ptr_d    = fa_q + AW'(4);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DACC: begin
                if (mis) begin
                    state_d = DRESP;
                    mis_d   = 1'b1;
                    flt_d   = 1'b0;
                end else begin
                    bus_addr = mem_addr;
                    bus_be   = be_base << offset;
                    if (mem_we) begin
                        bus_wr_n  = 1'b0;
                        bus_wdata = mem_wdata << {offset, 3'b000};
                    end else begin
                        bus_rd_n = 1'b0;
                    end
                    if (acc_end) begin
                        state_d = DRESP;
                        mis_d   = 1'b0;
                        flt_d   = acc_flt;
                        if (!mem_we && !acc_flt)
                            rdata_d = (bus_rdata >> {offset, 3'b000}) & rmask;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                mem_done = 1'b1;
                state_d  = IDLE;
            end
        endcase

        // A redirect wins over everything the fetch side decided this cycle.
        if (pf_flush) begin
            ptr_d  = pf_pc;
            hold_d = 1'b0;
            if (state_q == IFETCH && !acc_end)
                discard_d = 1'b1;
        end
    end

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        count_d  = count_q;
        if (pf_flush) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            count_d  = '0;
        end else begin
            rd_idx_d = rd_idx_q + PW'(pop);
            wr_idx_d = wr_idx_q + PW'(push);
            count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            fa_q        <= '0;
            hold_q      <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            done_prev_q <= 1'b0;
            rdata_q     <= '0;
            mis_q       <= 1'b0;
            flt_q       <= 1'b0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fa_q        <= fa_d;
            hold_q      <= hold_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            done_prev_q <= done_prev_d;
            rdata_q     <= rdata_d;
            mis_q       <= mis_d;
            flt_q       <= flt_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ins_q[wr_idx_q] <= push_ins;
            fifo_pc_q[wr_idx_q]  <= push_pc;
            fifo_flt_q[wr_idx_q] <= push_flt;
        end
    end

    assign ins_vld   = !empty;
    assign ins       = ins_vld ? fifo_ins_q[rd_idx_q] : '0;
    assign ins_pc    = ins_vld ? fifo_pc_q[rd_idx_q]  : '0;
    assign ins_fault = ins_vld && fifo_flt_q[rd_idx_q];
    assign mem_rdata = rdata_q;
    assign mem_mis   = mem_done && mis_q;
    assign mem_fault = mem_done && flt_q;

endmodule

// File: tb/tb_biu_pf.sv
// Directed bench for biu_pf (DW=32, PF_DEPTH=4, TIMEOUT=3); fetched words are bus_addr + 0x1000_0000.
module tb_biu_pf;

    logic        clk = 1'b0;
    logic        rst;
    logic        pf_flush;
    logic [31:0] pf_pc;
    logic [31:0] ins;
    logic        ins_vld;
    logic [31:0] ins_pc;
    logic        ins_fault;
    logic        ins_ack;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_mis;
    logic        mem_fault;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic [31:0] bus_rdata;
    logic        bus_rdy;
    logic        bus_acc_fault;
    logic        use_fix;
    logic [31:0] rd_fix;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign bus_rdata = use_fix ? rd_fix : bus_addr + 32'h1000_0000;

    biu_pf #(.DW(32), .AW(32), .PF_DEPTH(4), .TIMEOUT(3)) dut (
        .clk(clk), .rst(rst), .pf_flush(pf_flush), .pf_pc(pf_pc),
        .ins(ins), .ins_vld(ins_vld), .ins_pc(ins_pc), .ins_fault(ins_fault), .ins_ack(ins_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_mis(mem_mis),
        .mem_fault(mem_fault), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy),
        .bus_acc_fault(bus_acc_fault)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_vld(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ins_vld) begin got = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_done) begin got = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_strobe(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!bus_rd_n || !bus_wr_n) begin got = 1'b1; break; end
            tick();
        end
    endtask

    task automatic flush_to(input logic [31:0] pc);
        pf_flush = 1'b1;
        pf_pc    = pc;
        tick();
        pf_flush = 1'b0;
    endtask

    task automatic start_req(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    endtask

    task automatic test_reset;
        tick(); tick();
        n_cmp++; if (ins_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ins_vld got %0h want 0", ins_vld); end
        n_cmp++; if (ins !== 32'h0) begin n_bad++; $display("FAIL reset_ins got %0h want 0", ins); end
        n_cmp++; if ({bus_rd_n, bus_wr_n} !== 2'b11) begin n_bad++; $display("FAIL reset_strobes got %b want 11", {bus_rd_n, bus_wr_n}); end
        n_cmp++; if ({bus_be, bus_addr} !== 36'h0) begin n_bad++; $display("FAIL reset_bus got be=%h addr=%h want 0", bus_be, bus_addr); end
        n_cmp++; if ({mem_done, mem_mis, mem_fault, mem_rdata} !== 35'h0) begin n_bad++; $display("FAIL reset_mem got %h want 0", {mem_done, mem_mis, mem_fault, mem_rdata}); end
        bus_rdy = 1'b1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_prefetch_fill;
        int reads;
        flush_to(32'h100);
        repeat (15) tick();
        n_cmp++; if (ins_vld !== 1'b1 || ins_pc !== 32'h100) begin n_bad++; $display("FAIL fill_head got vld=%0h pc=%h want 1/100", ins_vld, ins_pc); end
        n_cmp++; if (ins !== 32'h1000_0100) begin n_bad++; $display("FAIL fill_ins got %h want 10000100", ins); end
        reads = 0;
        repeat (6) begin tick(); if (!bus_rd_n) reads++; end
        n_cmp++; if (reads != 0) begin n_bad++; $display("FAIL full_no_reads got %0d want 0", reads); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ins_pc !== 32'h100 + 32'(4 * i)) begin n_bad++; $display("FAIL fill_order%0d got %h want %h", i, ins_pc, 32'h100 + 32'(4 * i)); end
            ins_ack = 1'b1; tick(); ins_ack = 1'b0;
        end
        n_cmp++; if (ins_pc !== 32'h110) begin n_bad++; $display("FAIL refill_head got %h want 110", ins_pc); end
        repeat (12) tick();
    endtask

    task automatic test_flush_inflight;
        bit got;
        bus_rdy = 1'b0;
        flush_to(32'h10C);
        tick();
        n_cmp++; if (bus_rd_n !== 1'b0 || bus_addr !== 32'h10C) begin n_bad++; $display("FAIL fetch_10c got rd_n=%0h addr=%h want 0/10c", bus_rd_n, bus_addr); end
        pf_flush = 1'b1; pf_pc = 32'h400;
        tick();
        pf_flush = 1'b0; bus_rdy = 1'b1;
        tick();
        n_cmp++; if (ins_vld !== 1'b0) begin n_bad++; $display("FAIL drop_stale got vld=%0h pc=%h want 0", ins_vld, ins_pc); end
        wait_vld(got);
        n_cmp++; if (!got || ins_pc !== 32'h400 || ins !== 32'h1000_0400 || ins_fault !== 1'b0) begin
            n_bad++; $display("FAIL redirect_head got vld=%0h pc=%h ins=%h flt=%0h want 1/400/10000400/0", ins_vld, ins_pc, ins, ins_fault); end
        repeat (12) tick();
    endtask

    task automatic test_byte_load;
        bit got;
        use_fix = 1'b1; rd_fix = 32'hAABB_CCDD;
        start_req(1'b0, 2'd0, 32'h203, 32'h0);
        wait_strobe(got);
        n_cmp++; if (!got || bus_rd_n !== 1'b0 || bus_be !== 4'b1000 || bus_addr !== 32'h203) begin
            n_bad++; $display("FAIL byte_ld_bus got rd_n=%0h be=%b addr=%h want 0/1000/203", bus_rd_n, bus_be, bus_addr); end
        wait_done(got);
        n_cmp++; if (!got || mem_rdata !== 32'h0000_00AA || mem_mis !== 1'b0 || mem_fault !== 1'b0) begin
            n_bad++; $display("FAIL byte_ld_data got done=%0h rdata=%h mis=%0h flt=%0h want 1/000000aa/0/0", got, mem_rdata, mem_mis, mem_fault); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_half_store;
        bit got;
        start_req(1'b1, 2'd1, 32'h202, 32'h0000_1234);
        wait_strobe(got);
        n_cmp++; if (!got || bus_wr_n !== 1'b0 || bus_be !== 4'b1100 || bus_wdata !== 32'h1234_0000 || bus_addr !== 32'h202) begin
            n_bad++; $display("FAIL half_st_bus got wr_n=%0h be=%b wdata=%h addr=%h want 0/1100/12340000/202", bus_wr_n, bus_be, bus_wdata, bus_addr); end
        wait_done(got);
        n_cmp++; if (!got || mem_mis !== 1'b0 || mem_fault !== 1'b0 || mem_rdata !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL half_st_done got done=%0h mis=%0h flt=%0h rdata=%h want 1/0/0/000000aa", got, mem_mis, mem_fault, mem_rdata); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_misaligned_store;
        bit got;
        int wr_lo;
        start_req(1'b1, 2'd2, 32'h202, 32'h5555_AAAA);
        got = 1'b0; wr_lo = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus_wr_n) wr_lo++;
            if (mem_done) begin got = 1'b1; break; end
        end
        n_cmp++; if (!got || mem_mis !== 1'b1 || mem_fault !== 1'b0) begin n_bad++; $display("FAIL mis_st_done got done=%0h mis=%0h flt=%0h want 1/1/0", got, mem_mis, mem_fault); end
        n_cmp++; if (wr_lo != 0) begin n_bad++; $display("FAIL mis_st_strobe got %0d wr cycles want 0", wr_lo); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        bit got;
        int n;
        bus_rdy = 1'b0;
        start_req(1'b0, 2'd2, 32'h300, 32'h0);
        wait_strobe(got);
        n = 0; got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(); n++;
            if (mem_done) begin got = 1'b1; break; end
        end
        n_cmp++; if (!got || n != 4) begin n_bad++; $display("FAIL timeout_cycles got done=%0h after %0d want 1 after 4", got, n); end
        n_cmp++; if (mem_fault !== 1'b1 || mem_mis !== 1'b0 || mem_rdata !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL timeout_resp got flt=%0h mis=%0h rdata=%h want 1/0/000000aa", mem_fault, mem_mis, mem_rdata); end
        mem_req = 1'b0; bus_rdy = 1'b1;
        tick();
    endtask

    task automatic test_fault_wins;
        bit got;
        bus_acc_fault = 1'b1;
        start_req(1'b0, 2'd2, 32'h304, 32'h0);
        wait_done(got);
        n_cmp++; if (!got || mem_fault !== 1'b1 || mem_rdata !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL fault_wins got done=%0h flt=%0h rdata=%h want 1/1/000000aa", got, mem_fault, mem_rdata); end
        mem_req = 1'b0; bus_acc_fault = 1'b0;
        tick();
    endtask

    task automatic test_data_priority;
        bit got;
        use_fix = 1'b0; bus_rdy = 1'b0;
        ins_ack = 1'b1; tick(); tick(); ins_ack = 1'b0;
        wait_strobe(got);
        n_cmp++; if (!got || bus_rd_n !== 1'b0 || bus_be !== 4'hF || bus_addr[1:0] !== 2'b00) begin
            n_bad++; $display("FAIL prio_fetch got rd_n=%0h be=%b addr=%h want 0/1111/aligned", bus_rd_n, bus_be, bus_addr); end
        start_req(1'b1, 2'd2, 32'h500, 32'hDEAD_BEEF);
        bus_rdy = 1'b1;
        tick();
        wait_strobe(got);
        n_cmp++; if (!got || bus_wr_n !== 1'b0 || bus_rd_n !== 1'b1 || bus_addr !== 32'h500 || bus_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL prio_data got wr_n=%0h rd_n=%0h addr=%h wdata=%h want 0/1/500/deadbeef", bus_wr_n, bus_rd_n, bus_addr, bus_wdata); end
        wait_done(got);
        n_cmp++; if (!got || mem_fault !== 1'b0) begin n_bad++; $display("FAIL prio_done got done=%0h flt=%0h want 1/0", got, mem_fault); end
        mem_req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_fetch_fault;
        bit got;
        int reads;
        bus_acc_fault = 1'b1;
        flush_to(32'h700);
        wait_vld(got);
        bus_acc_fault = 1'b0;
        n_cmp++; if (!got || ins_pc !== 32'h700 || ins_fault !== 1'b1 || ins !== 32'h0) begin
            n_bad++; $display("FAIL fetch_fault got vld=%0h pc=%h flt=%0h ins=%h want 1/700/1/0", got, ins_pc, ins_fault, ins); end
        reads = 0;
        repeat (6) begin tick(); if (!bus_rd_n) reads++; end
        n_cmp++; if (reads != 0) begin n_bad++; $display("FAIL fault_hold got %0d reads want 0", reads); end
        ins_ack = 1'b1; tick(); ins_ack = 1'b0;
        n_cmp++; if (ins_vld !== 1'b0) begin n_bad++; $display("FAIL fault_single got vld=%0h want 0", ins_vld); end
    endtask

    task automatic test_misaligned_pc;
        bit got;
        int reads;
        flush_to(32'h402);
        reads = 0;
        repeat (6) begin tick(); if (!bus_rd_n) reads++; end
        n_cmp++; if (reads != 0) begin n_bad++; $display("FAIL mis_pc_reads got %0d want 0", reads); end
        n_cmp++; if (ins_vld !== 1'b1 || ins_fault !== 1'b1 || ins_pc !== 32'h402) begin
            n_bad++; $display("FAIL mis_pc_entry got vld=%0h flt=%0h pc=%h want 1/1/402", ins_vld, ins_fault, ins_pc); end
        ins_ack = 1'b1; tick(); ins_ack = 1'b0;
        n_cmp++; if (ins_vld !== 1'b0) begin n_bad++; $display("FAIL mis_pc_single got vld=%0h want 0", ins_vld); end
        ins_ack = 1'b1; tick(); ins_ack = 1'b0; tick();
        n_cmp++; if (ins_vld !== 1'b0) begin n_bad++; $display("FAIL empty_ack got vld=%0h want 0", ins_vld); end
        flush_to(32'h600);
        wait_vld(got);
        n_cmp++; if (!got || ins_pc !== 32'h600 || ins !== 32'h1000_0600) begin
            n_bad++; $display("FAIL after_empty_ack got vld=%0h pc=%h ins=%h want 1/600/10000600", got, ins_pc, ins); end
        repeat (10) tick();
    endtask

    task automatic test_reset_midaccess;
        bit got;
        bus_rdy = 1'b0;
        start_req(1'b0, 2'd2, 32'h800, 32'h0);
        wait_strobe(got);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (!got || bus_rd_n !== 1'b1 || bus_be !== 4'h0 || bus_addr !== 32'h0) begin
            n_bad++; $display("FAIL async_reset got seen=%0h rd_n=%0h be=%b addr=%h want 1/1/0000/0", got, bus_rd_n, bus_be, bus_addr); end
        mem_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; pf_flush = 1'b0; pf_pc = '0; ins_ack = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        bus_rdy = 1'b0; bus_acc_fault = 1'b0; use_fix = 1'b0; rd_fix = '0;
        test_reset();
        test_prefetch_fill();
        test_flush_inflight();
        test_byte_load();
        test_half_store();
        test_misaligned_store();
        test_timeout();
        test_fault_wins();
        test_data_priority();
        test_fetch_fault();
        test_misaligned_pc();
        test_reset_midaccess();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/biu_pf.md
BIU_PF -- requirements
Module: biu_pf

Interface
REQ-001 SHALL have parameter DW, default 32, bus data width; legal values are 32 or 64.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter PF_DEPTH, default 4, instruction prefetch FIFO entries; power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 255, bus wait-cycle limit; 0 disables the limit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port pf_flush, input, 1 bit: redirect the prefetch stream to pf_pc.
REQ-008 SHALL have port pf_pc, input, AW bits: redirect target.
REQ-009 SHALL have port ins, output, 32 bits: instruction at the FIFO head.
REQ-010 SHALL have port ins_vld, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port ins_pc, output, AW bits: address of the head instruction.
REQ-012 SHALL have port ins_fault, output, 1 bit: the head entry faulted.
REQ-013 SHALL have port ins_ack, input, 1 bit: pop the head entry.
REQ-014 SHALL have port mem_req, input, 1 bit: data access request; held until mem_done.
REQ-015 SHALL have port mem_we, input, 1 bit: 1 selects store.
REQ-016 SHALL have port mem_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DW is 64).
REQ-017 SHALL have port mem_addr, input, AW bits: data address.
REQ-018 SHALL have port mem_wdata, input, DW bits: store data, right-aligned.
REQ-019 SHALL have port mem_rdata, output, DW bits: load data, right-aligned and zero-extended.
REQ-020 SHALL have port mem_done, output, 1 bit: one-cycle pulse at access completion.
REQ-021 SHALL have port mem_mis, output, 1 bit: misaligned access, qualified by mem_done.
REQ-022 SHALL have port mem_fault, output, 1 bit: bus fault or timeout, qualified by mem_done.
REQ-023 SHALL have port bus_addr, output, AW bits: bus address.
REQ-024 SHALL have port bus_wdata, output, DW bits: lane-positioned store data.
REQ-025 SHALL have port bus_be, output, DW/8 bits: byte-lane enables.
REQ-026 SHALL have port bus_rd_n, output, 1 bit: read strobe, active low.
REQ-027 SHALL have port bus_wr_n, output, 1 bit: write strobe, active low.
REQ-028 SHALL have port bus_rdata, input, DW bits: bus read data.
REQ-029 SHALL have port bus_rdy, input, 1 bit: the current bus access completes this cycle.
REQ-030 SHALL have port bus_acc_fault, input, 1 bit: the current bus access failed this cycle.

Function
REQ-031 SHALL implement FSM states IDLE, IFETCH, DACC and DRESP, with at most one bus access outstanding.
REQ-032 In IDLE, SHALL give a pending data request priority: IDLE->DACC when mem_req is high and mem_done was not asserted in the previous cycle.
REQ-033 Otherwise, SHALL go IDLE->IFETCH when the FIFO is not full (free entries exceed 0, counting no in-flight fetch) and no fetch fault is held.
REQ-034 During IFETCH, bus_addr SHALL be the fetch pointer with bits [1:0] = 0, bus_rd_n = 0, and all bus_be bits = 1.
REQ-035 For fetch with DW = 64, SHALL select the instruction from lane pc[2].
REQ-036 A fetch completing on bus_rdy SHALL push {instruction, pc, fault=0}, advance the pointer by 4, and return to IDLE.
REQ-037 A fetch completing on fault or timeout SHALL push {0, pc, fault=1} and stop prefetching until pf_flush.
REQ-038 A misaligned pf_pc (bits [1:0] nonzero) SHALL push one faulted entry without a bus cycle.
REQ-039 pf_flush SHALL empty the FIFO and load the pointer from pf_pc in the same cycle.
REQ-040 A fetch in flight at pf_flush SHALL complete on the bus with its result discarded.
REQ-041 pf_flush SHALL take priority over a simultaneous push and over ins_ack.
REQ-042 ins_ack with an empty FIFO SHALL be ignored.
REQ-043 A push and a pop in the same cycle SHALL be legal when the FIFO is full; occupancy is unchanged.
REQ-044 Entering DACC, SHALL check alignment: a half access is misaligned at addr[0] = 1; a word access at addr[1:0] nonzero; a dword access at addr[2:0] nonzero.
REQ-045 A misaligned access SHALL go DACC->DRESP in one cycle with no bus strobe, and mem_mis = 1 at mem_done.
REQ-046 An aligned access in DACC SHALL drive bus_addr = mem_addr, shift bus_wdata and bus_be to the addressed lanes, and assert bus_wr_n = 0 for a store or bus_rd_n = 0 for a load.
REQ-047 The strobes SHALL be held until bus_rdy or bus_acc_fault.
REQ-048 If bus_rdy and bus_acc_fault are asserted together, fault SHALL win.
REQ-049 On a load, SHALL register mem_rdata as the addressed lanes shifted to bit 0 and zero-extended.
REQ-050 DRESP SHALL assert mem_done for exactly one cycle, then go DRESP->IDLE.
REQ-051 mem_rdata SHALL hold its value until the next load completes.
REQ-052 The wait counter SHALL clear when IFETCH or DACC is entered and increment on each cycle without bus_rdy.
REQ-053 When the counter equals TIMEOUT and TIMEOUT is nonzero, the access SHALL terminate as a fault.
REQ-054 Outside IFETCH and DACC, SHALL hold bus_rd_n = 1, bus_wr_n = 1, bus_be = 0 and bus_addr = 0.

Reset
REQ-055 While rst is high, SHALL set state IDLE, FIFO empty, fetch pointer 0, fetch-fault hold 0, wait counter 0, and every output to 0 except bus_rd_n = 1 and bus_wr_n = 1.
REQ-056 Reset asserted mid-access SHALL abandon the access, with the strobes deasserted asynchronously.

Verification
REQ-057 Verification SHALL cover: flush to pf_pc 0x100 with bus_rdy always 1 -> ins_pc 0x100, 0x104, 0x108, 0x10C; FIFO full after 4 entries; no further bus reads until ins_ack.
REQ-058 Verification SHALL cover: with DW = 32, byte load at 0x203 returning bus_rdata 0xAABBCCDD -> bus_be = 1000 and mem_rdata 0x000000AA.
REQ-059 Verification SHALL cover: word store at 0x202 -> mem_done with mem_mis = 1 and no bus_wr_n pulse.
REQ-060 Verification SHALL cover: with TIMEOUT = 3 and bus_rdy held 0 -> mem_fault at mem_done, four wait cycles after the access starts.
REQ-061 Verification SHALL cover: pf_flush to 0x400 during an in-flight fetch of 0x10C -> that result is dropped and the first entry has ins_pc 0x400.
REQ-062 Verification SHALL cover: mem_req asserted while a fetch is outstanding -> the data access starts the cycle after the fetch completes, ahead of the next prefetch.
